// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the PC, issues one fetch at a time to instruction memory, registers
// the returned word for decode and loads either PC+4 or a redirect target.
// A redirect that arrives while a fetch is outstanding is parked until the
// memory acknowledges, so the fetch address never changes mid-request.
module pc_fetch_unit #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fault
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic             squash;
    logic             squash_nxt;
    logic [WIDTH-1:0] squash_target;
    logic [WIDTH-1:0] target_nxt;
    logic             capture;
    logic             fault_nxt;
    logic             load_req;
    logic [WIDTH-1:0] load_val;

    // The fetch address is the PC itself; no separate address register.
    assign imem_addr = pc;

    // Next-state, next-PC and squash bookkeeping; every PC load goes through
    // one alignment check so a misaligned target can never reach the PC.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        target_nxt = squash_target;
        capture    = 1'b0;
        fault_nxt  = fault;
        load_req   = 1'b0;
        load_val   = '0;

        case (state)
            IDLE: begin
                // A late ack from before reset is ignored here.
                state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        load_req = 1'b1;
                        load_val = redirect_target;
                    end else if (squash) begin
                        load_req = 1'b1;
                        load_val = squash_target;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = DELIVER;
                    end
                end else if (redirect) begin
                    // Request still outstanding: park the newest target.
                    squash_nxt = 1'b1;
                    target_nxt = redirect_target;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    load_req = 1'b1;
                    load_val = redirect_target;
                end else if (instr_ready) begin
                    load_req = 1'b1;
                    load_val = pc_plus4;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (load_req) begin
            squash_nxt = 1'b0;
            if (load_val[1:0] != 2'b00) begin
                state_nxt = FAULT;
                fault_nxt = 1'b1;
            end else begin
                pc_nxt    = load_val;
                state_nxt = FETCH;
            end
        end
    end

    // Control and output registers; the request and valid flags are derived
    // from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
            squash      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            imem_req    <= (state_nxt == FETCH);
            instr_valid <= (state_nxt == DELIVER);
            fault       <= fault_nxt;
            squash      <= squash_nxt;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

    // Parked redirect target; only meaningful while squash is set.
    always_ff @(posedge clk) begin
        squash_target <= target_nxt;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: a small memory responder acks
// requests after a programmable delay and returns an address-derived word,
// and a PC+4 adder model feeds pc_plus4.
module tb_pc_fetch_unit;

    localparam logic [63:0] RPC = 64'h0000_0000_0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        redirect;
    logic [63:0] redirect_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        fault;

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_delay = 0;
    int req_age   = 0;
    bit force_ack = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.WIDTH(64), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .fault           (fault)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // Memory responder and PC+4 adder model, updated mid-cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc_plus4   = '0;
        forever begin
            @(negedge clk);
            pc_plus4   = pc + 64'd4;
            imem_rdata = mem_word(imem_addr);
            if (force_ack) begin
                imem_ack = 1'b1;
            end else if (imem_req === 1'b1) begin
                if (req_age >= ack_delay) begin
                    imem_ack = 1'b1;
                    req_age  = 0;
                end else begin
                    imem_ack = 1'b0;
                    req_age++;
                end
            end else begin
                imem_ack = 1'b0;
                req_age  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
        n_cmp++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    endtask

    task automatic test_sequence();
        logic [63:0] a;
        reset_n = 1'b1;
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_first_req: got %b want 1", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 3; k++) begin
            a = RPC + 64'(4 * k);
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, instr_valid); end
            n_cmp++; if (instr_pc !== a) begin n_fail++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", k, instr_pc, a); end
            n_cmp++; if (instr !== mem_word(a)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", k, instr, mem_word(a)); end
            tick();
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_gap_valid[%0d]: got %b want 0", k, instr_valid); end
            n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b want 1", k, imem_req); end
            n_cmp++; if (pc !== a + 64'd4) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc, a + 64'd4); end
        end
    endtask

    task automatic test_stall();
        logic [63:0] a;
        a = RPC + 64'd12;
        instr_ready = 1'b0;
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_enter_valid: got %b want 1", instr_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
            n_cmp++; if (instr_pc !== a) begin n_fail++; $display("FAIL stall_instr_pc[%0d]: got %h want %h", i, instr_pc, a); end
            n_cmp++; if (instr !== mem_word(a)) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, mem_word(a)); end
            n_cmp++; if (pc !== a) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, a); end
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
        end
        instr_ready = 1'b1;
        tick();
        n_cmp++; if (pc !== a + 64'd4) begin n_fail++; $display("FAIL stall_release_pc: got %h want %h", pc, a + 64'd4); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req: got %b want 1", imem_req); end
        instr_ready = 1'b0;
        tick();
        n_cmp++; if (pc !== a + 64'd4) begin n_fail++; $display("FAIL stall_once_pc: got %h want %h", pc, a + 64'd4); end
        n_cmp++; if (instr_pc !== a + 64'd4) begin n_fail++; $display("FAIL stall_next_instr_pc: got %h want %h", instr_pc, a + 64'd4); end
    endtask

    task automatic test_redirect_fetch();
        logic [63:0] a;
        a = RPC + 64'd20;
        ack_delay   = 3;
        instr_ready = 1'b1;
        tick();
        redirect        = 1'b1;
        redirect_target = 64'h1000;
        tick();
        redirect = 1'b0;
        n_cmp++; if (pc !== a) begin n_fail++; $display("FAIL rdf_pc_held: got %h want %h", pc, a); end
        n_cmp++; if (imem_addr !== a) begin n_fail++; $display("FAIL rdf_addr_held: got %h want %h", imem_addr, a); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdf_req_held: got %b want 1", imem_req); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_wait_valid[%0d]: got %b want 0", i, instr_valid); end
            n_cmp++; if (pc !== a) begin n_fail++; $display("FAIL rdf_wait_pc[%0d]: got %h want %h", i, pc, a); end
        end
        tick();
        n_cmp++; if (imem_addr !== 64'h1000) begin n_fail++; $display("FAIL rdf_new_addr: got %h want 1000", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_dropped_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdf_new_req: got %b want 1", imem_req); end
        ack_delay   = 0;
        instr_ready = 1'b0;
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rdf_deliver_valid: got %b want 1", instr_valid); end
        n_cmp++; if (instr_pc !== 64'h1000) begin n_fail++; $display("FAIL rdf_deliver_pc: got %h want 1000", instr_pc); end
        n_cmp++; if (instr !== mem_word(64'h1000)) begin n_fail++; $display("FAIL rdf_deliver_instr: got %h want %h", instr, mem_word(64'h1000)); end
    endtask

    task automatic test_redirect_deliver();
        instr_ready     = 1'b1;
        redirect        = 1'b1;
        redirect_target = 64'h2000;
        tick();
        redirect = 1'b0;
        n_cmp++; if (pc !== 64'h2000) begin n_fail++; $display("FAIL rdd_pc: got %h want 2000", pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdd_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdd_req: got %b want 1", imem_req); end
        instr_ready = 1'b0;
        tick();
        n_cmp++; if (instr_pc !== 64'h2000) begin n_fail++; $display("FAIL rdd_instr_pc: got %h want 2000", instr_pc); end
    endtask

    task automatic test_wrap();
        redirect        = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        n_cmp++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_load_pc: got %h want fffffffffffffffc", pc); end
        tick();
        n_cmp++; if (instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_instr_pc: got %h want fffffffffffffffc", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL wrap_fault: got %b want 0", fault); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b want 1", imem_req); end
    endtask

    task automatic test_fault();
        tick();
        n_cmp++; if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL flt_pre_instr_pc: got %h want 0", instr_pc); end
        redirect        = 1'b1;
        redirect_target = 64'h1002;
        tick();
        n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL flt_set: got %b want 1", fault); end
        n_cmp++; if (pc !== 64'h0) begin n_fail++; $display("FAIL flt_pc_kept: got %h want 0", pc); end
        redirect_target = 64'h3000;
        instr_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (fault !== 1'b1) begin n_fail++; $display("FAIL flt_sticky[%0d]: got %b want 1", i, fault); end
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flt_req[%0d]: got %b want 0", i, imem_req); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flt_valid[%0d]: got %b want 0", i, instr_valid); end
            n_cmp++; if (pc !== 64'h0) begin n_fail++; $display("FAIL flt_pc[%0d]: got %h want 0", i, pc); end
        end
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL flt_reset_fault: got %b want 0", fault); end
        n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL flt_reset_pc: got %h want %h", pc, RPC); end
    endtask

    task automatic test_async_reset();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (instr_pc !== RPC) begin n_fail++; $display("FAIL ar_pre_instr_pc: got %h want %h", instr_pc, RPC); end
        ack_delay   = 5;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        n_cmp++; if (pc !== RPC + 64'd4) begin n_fail++; $display("FAIL ar_pre_pc: got %h want %h", pc, RPC + 64'd4); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre_req: got %b want 1", imem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL ar_pc: got %h want %h", pc, RPC); end
        n_cmp++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL ar_addr: got %h want %h", imem_addr, RPC); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL ar_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ar_fault: got %b want 0", fault); end
    endtask

    task automatic test_late_ack();
        ack_delay = 0;
        force_ack = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        force_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL late_ack_req: got %b want 1", imem_req); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL late_ack_instr: got %h want 0", instr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL late_ack_fetch_valid: got %b want 1", instr_valid); end
        n_cmp++; if (instr_pc !== RPC) begin n_fail++; $display("FAIL late_ack_fetch_pc: got %h want %h", instr_pc, RPC); end
    endtask

    initial begin
        reset_n         = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b1;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_fetch();
        test_redirect_deliver();
        test_wrap();
        test_fault();
        test_async_reset();
        test_late_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the single-issue datapath. Holds the 64-bit PC, drives it to the PC+4 adder and the instruction memory, and loads either the adder's result or a branch redirect target. A req/ack handshake with instruction memory and a valid/ready handshake with the decode stage give the block its sequencing; the delivered instruction is registered.

## Interface
- WIDTH, 64, PC and address width
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- pc  out  WIDTH  current PC; feeds the PC+4 adder input
- pc_plus4  in  WIDTH  adder result (pc + 4, modulo 2^WIDTH)
- redirect  in  1  branch/jump taken this cycle
- redirect_target  in  WIDTH  new PC when redirect=1
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address (equals pc)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc are valid for decode
- instr_ready  in  1  decode accepts this cycle
- instr  out  32  registered instruction
- instr_pc  out  WIDTH  PC of the delivered instruction
- fault  out  1  sticky misaligned-target error

## Operation
- States: IDLE, FETCH, DELIVER, FAULT.
- IDLE: entered only from reset; next cycle -> FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. On ack: if no pending squash, capture imem_rdata -> instr, pc -> instr_pc, go DELIVER; if squash pending, discard data, load pc <= stored target, clear squash, stay FETCH (new request next cycle).
- redirect during FETCH before/without ack: store redirect_target, set squash; pc is not changed while the request is outstanding. A later redirect in the same FETCH overwrites the stored target. redirect in the ack cycle: data discarded, pc <= redirect_target, stay FETCH.
- DELIVER: instr_valid=1; instr, instr_pc held. instr_ready=1 and redirect=0: pc <= pc_plus4, -> FETCH. redirect=1 (regardless of instr_ready): instruction dropped (transfer does not count), pc <= redirect_target, -> FETCH. instr_ready=0 and redirect=0: hold.
- Misalignment: any target to be loaded with bits [1:0] != 0 -> pc unchanged, fault=1, -> FAULT. FAULT: imem_req=0, instr_valid=0, ignores all inputs until reset.
- pc_plus4 is taken as-is; 0xFFFF_FFFF_FFFF_FFFC advances to 0 with no error.
- PC advances only via the DELIVER handshake or a redirect; never on ack alone.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0, squash cleared.
- Release in cycle 0 (first edge with reset_n=1): IDLE->FETCH; imem_req=1 from cycle 1.
- ack in cycle N -> instr_valid=1 in cycle N+1; best-case throughput one instruction per 2 cycles (FETCH, DELIVER).
- Handshake at edge with valid&ready -> new pc and imem_req=1 visible the next cycle.
- Redirect takes effect on pc the cycle after it is sampled, except when deferred by an outstanding request, when it takes effect the cycle after ack.
- All outputs registered, except imem_addr, which is wired to pc.
- Reset asserted mid-fetch: outstanding request abandoned. A late ack after release, arriving while in IDLE, is ignored.

## Test plan
- Reset with RESET_PC=0x400000, ack 1 cycle after each req, instr_ready=1 -> instr_pc sequence 0x400000, 0x400004, 0x400008, with instr_valid pulsing every 2nd cycle.
- DELIVER with instr_ready=0 for 5 cycles -> instr and instr_pc stable, pc unchanged, imem_req=0; release -> pc advances by 4 exactly once.
- redirect to 0x1000 during FETCH, ack 3 cycles later -> data dropped, no instr_valid, next imem_addr=0x1000; redirect coinciding with the DELIVER handshake -> instruction not counted, next fetch at target.
- pc=0xFFFF_FFFF_FFFF_FFFC delivered -> next imem_addr=0, fault=0.
- redirect_target=0x1002 -> fault=1, imem_req=0 permanently; reset_n low -> fault=0, pc=RESET_PC.
- reset_n asserted asynchronously mid-FETCH -> outputs at reset values immediately, without waiting for a clock edge.
